array_pingpong_buffer: RTL



---
 rtl/array_pingpong_buffer_pkg.sv | 15 +
 rtl/array_bank_reg.sv | 23 ++
 rtl/array_pingpong_buffer.sv | 95 +++++++++
 3 files changed

// File: rtl/array_pingpong_buffer_pkg.sv
// rtl/array_pingpong_buffer_pkg.sv - shared types and constants for the ping-pong array buffer
package array_pingpong_buffer_pkg;

   localparam int ARRAY_N = 3;
   localparam int ARRAY_W = 2;

   typedef logic [ARRAY_W-1:0] elem_t;
   typedef elem_t [ARRAY_N-1:0] array_t;
   typedef logic bank_sel_t;

   function automatic bank_sel_t next_bank(input bank_sel_t b);
      return ~b;
   endfunction

endpackage

// File: rtl/array_bank_reg.sv
// rtl/array_bank_reg.sv - one N x W register bank with write enable and synchronous reset
module array_bank_reg
   import array_pingpong_buffer_pkg::*;
#(
   parameter int N = ARRAY_N,
   parameter int W = ARRAY_W
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                we,
   input  logic [N-1:0][W-1:0] d,
   output logic [N-1:0][W-1:0] q
);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         q <= '0;
      end else if (we) begin
         q <= d;
      end
   end

endmodule

// File: rtl/array_pingpong_buffer.sv
// rtl/array_pingpong_buffer.sv - two-bank ping-pong buffer feeding a 2:1 array mux
// Optional stall counter port is enabled by defining ARRAY_PINGPONG_STALL_COUNT_EN.
module array_pingpong_buffer
   import array_pingpong_buffer_pkg::*;
#(
   parameter int N = ARRAY_N,
   parameter int W = ARRAY_W
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N-1:0][W-1:0] in_data,
   output logic [N-1:0][W-1:0] bank0,
   output logic [N-1:0][W-1:0] bank1,
   output logic                sel,
   output logic                out_valid,
   input  logic                out_ready
`ifdef ARRAY_PINGPONG_STALL_COUNT_EN
   ,
   output logic [15:0]         stall_count
`endif
);

   logic [1:0] full;
   bank_sel_t  wbank;
   bank_sel_t  rbank;
   logic       wr_fire;
   logic       rd_fire;
   logic       we0;
   logic       we1;

   // Handshake outputs come only from registered state, so in_ready never
   // depends combinationally on out_ready.
   assign in_ready  = ~full[wbank];
   assign out_valid = full[rbank];
   assign sel       = rbank;

   assign wr_fire = in_valid & in_ready;
   assign rd_fire = out_valid & out_ready;
   assign we0     = wr_fire & (wbank == 1'b0);
   assign we1     = wr_fire & (wbank == 1'b1);

   // A simultaneous write and read always hit different banks, so the two
   // bit updates of full never collide.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         full  <= 2'b00;
         wbank <= 1'b0;
         rbank <= 1'b0;
      end else begin
         if (wr_fire) begin
            full[wbank] <= 1'b1;
            wbank       <= next_bank(wbank);
         end
         if (rd_fire) begin
            full[rbank] <= 1'b0;
            rbank       <= next_bank(rbank);
         end
      end
   end

   array_bank_reg #(
      .N(N),
      .W(W)
   ) u_bank0 (
      .CLK  (CLK),
      .RESET(RESET),
      .we   (we0),
      .d    (in_data),
      .q    (bank0)
   );

   array_bank_reg #(
      .N(N),
      .W(W)
   ) u_bank1 (
      .CLK  (CLK),
      .RESET(RESET),
      .we   (we1),
      .d    (in_data),
      .q    (bank1)
   );

`ifdef ARRAY_PINGPONG_STALL_COUNT_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         stall_count <= 16'h0000;
      end else if (in_valid && !in_ready && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'h0001;
      end
   end
`endif

endmodule
